// File: rtl/controlador_memoria_pkg.sv
// Shared memory-map constants and region decode for controlador_memoria and
// any future peripheral or bench that needs to agree on the address layout.
package controlador_memoria_pkg;

  localparam logic [31:0] BASE_RAM       = 32'h0000_0000;
  localparam logic [31:0] BASE_PERIF     = 32'h8000_0000;
  localparam logic [31:0] DIR_GPIO       = BASE_PERIF + 32'h0;
  localparam logic [31:0] DIR_CONTADOR   = BASE_PERIF + 32'h4;
  localparam logic [31:0] DIR_COMPARADOR = BASE_PERIF + 32'h8;
  localparam logic [31:0] DIR_ESTADO     = BASE_PERIF + 32'hC;

  localparam logic [27:0] PREFIJO_PERIF  = 28'h800_0000;

  localparam int BIT_IRQ = 0;
  localparam int BIT_ERR = 1;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_GPIO,
    SEL_CONTADOR,
    SEL_COMPARADOR,
    SEL_ESTADO,
    SEL_NINGUNO
  } region_t;

  // Word-granular decode; the two low address bits never affect the region.
  function automatic region_t decodificar(input logic [31:0] dir, input int ancho_dir);
    region_t r;
    r = SEL_NINGUNO;
    if ((dir >> (ancho_dir + 2)) == 32'd0) begin
      r = SEL_RAM;
    end else if (dir[31:4] == PREFIJO_PERIF) begin
      case (dir[3:2])
        2'd0:    r = SEL_GPIO;
        2'd1:    r = SEL_CONTADOR;
        2'd2:    r = SEL_COMPARADOR;
        default: r = SEL_ESTADO;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_sincrona.sv
// Single-port synchronous RAM, read-first, 32-bit words.
module ram_sincrona #(
  parameter int    ANCHO_DIR    = 10,
  parameter string ARCHIVO_INIT = ""
) (
  input  logic                 clk,
  input  logic                 hab_escritura,
  input  logic [ANCHO_DIR-1:0] dir,
  input  logic [31:0]          dat_escritura,
  output logic [31:0]          dat_lectura
);

  logic [31:0] mem [0:(1<<ANCHO_DIR)-1];

  // Read sees the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (hab_escritura) begin
      mem[dir] <= dat_escritura;
    end
    dat_lectura <= mem[dir];
  end

endmodule

// File: rtl/controlador_memoria.sv
// Memory-mapped controller: RAM, GPIO, timer and sticky status flags.
// Timer (CONTADOR/COMPARADOR/irq) built only with CONTROLADOR_MEMORIA_TEMPORIZADOR_EN.
module controlador_memoria
  import controlador_memoria_pkg::*;
#(
  parameter int    ANCHO_DIR    = 10,
  parameter string ARCHIVO_INIT = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dir,
  input  logic [31:0] dat_escritura,
  input  logic        hab_escritura,
  output logic [31:0] dat_lectura,
  output logic [7:0]  salida_gpio,
  output logic        irq_temporizador,
  output logic        err_bus
);

  region_t     region;
  logic        desalineado;
  logic        error_acceso;
  logic        escritura_ok;
  logic        limpia_irq;
  logic        limpia_err;
  logic [31:0] ram_dato;
  logic [31:0] lectura_perif;
  logic [31:0] contador_val;
  logic [31:0] comparador_val;
  logic        irq_flag;

  logic [7:0]  gpio_reg;
  logic        err_reg;
  logic [31:0] lectura_perif_reg;
  logic        lectura_ram_reg;

  assign region       = decodificar(dir, ANCHO_DIR);
  assign desalineado  = hab_escritura && (dir[1:0] != 2'b00);
  assign error_acceso = (region == SEL_NINGUNO) || desalineado;
  // Gating with reset keeps the un-reset RAM from taking a write during reset.
  assign escritura_ok = hab_escritura && !error_acceso && reset;
  assign limpia_irq   = escritura_ok && (region == SEL_ESTADO) && dat_escritura[BIT_IRQ];
  assign limpia_err   = escritura_ok && (region == SEL_ESTADO) && dat_escritura[BIT_ERR];

  ram_sincrona #(
    .ANCHO_DIR    (ANCHO_DIR),
    .ARCHIVO_INIT (ARCHIVO_INIT)
  ) u_ram (
    .clk           (clk),
    .hab_escritura (escritura_ok && (region == SEL_RAM)),
    .dir           (dir[ANCHO_DIR+1:2]),
    .dat_escritura (dat_escritura),
    .dat_lectura   (ram_dato)
  );

`ifdef CONTROLADOR_MEMORIA_TEMPORIZADOR_EN
  logic [31:0] contador_reg;
  logic [31:0] comparador_reg;
  logic        irq_reg;

  // A match in this cycle beats a same-cycle W1C of the irq bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contador_reg   <= '0;
      comparador_reg <= '0;
      irq_reg        <= 1'b0;
    end else begin
      contador_reg <= contador_reg + 32'd1;
      if (escritura_ok && (region == SEL_COMPARADOR)) begin
        comparador_reg <= dat_escritura;
      end
      if (contador_reg == comparador_reg) begin
        irq_reg <= 1'b1;
      end else if (limpia_irq) begin
        irq_reg <= 1'b0;
      end
    end
  end

  assign contador_val   = contador_reg;
  assign comparador_val = comparador_reg;
  assign irq_flag       = irq_reg;
`else
  assign contador_val   = '0;
  assign comparador_val = '0;
  assign irq_flag       = 1'b0;
`endif

  always_comb begin
    lectura_perif = '0;
    case (region)
      SEL_GPIO:       lectura_perif = {24'd0, gpio_reg};
      SEL_CONTADOR:   lectura_perif = contador_val;
      SEL_COMPARADOR: lectura_perif = comparador_val;
      SEL_ESTADO:     lectura_perif = {30'd0, err_reg, irq_flag};
      default:        lectura_perif = '0;
    endcase
    if (error_acceso) begin
      lectura_perif = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_reg          <= '0;
      err_reg           <= 1'b0;
      lectura_perif_reg <= '0;
      lectura_ram_reg   <= 1'b0;
    end else begin
      lectura_perif_reg <= lectura_perif;
      lectura_ram_reg   <= (region == SEL_RAM) && !error_acceso;
      if (escritura_ok && (region == SEL_GPIO)) begin
        gpio_reg <= dat_escritura[7:0];
      end
      if (error_acceso) begin
        err_reg <= 1'b1;
      end else if (limpia_err) begin
        err_reg <= 1'b0;
      end
    end
  end

  // RAM data has its own output register; the peripheral path is registered here.
  assign dat_lectura      = lectura_ram_reg ? ram_dato : lectura_perif_reg;
  assign salida_gpio      = gpio_reg;
  assign irq_temporizador = irq_flag;
  assign err_bus          = err_reg;

endmodule

// File: tb/tb_controlador_memoria.sv
// Self-checking bench for controlador_memoria: directed scenarios plus random
// traffic checked every cycle against a behavioural address-map model.
module tb_controlador_memoria;
  import controlador_memoria_pkg::*;

  localparam int          ANCHO     = 10;
  localparam int          RAM_WORDS = 1 << ANCHO;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
`ifdef CONTROLADOR_MEMORIA_TEMPORIZADOR_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dir = '0;
  logic [31:0] dat_escritura = '0;
  logic        hab_escritura = 1'b0;
  logic [31:0] dat_lectura;
  logic [7:0]  salida_gpio;
  logic        irq_temporizador;
  logic        err_bus;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  controlador_memoria #(
    .ANCHO_DIR    (ANCHO),
    .ARCHIVO_INIT ("")
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .dir              (dir),
    .dat_escritura    (dat_escritura),
    .hab_escritura    (hab_escritura),
    .dat_lectura      (dat_lectura),
    .salida_gpio      (salida_gpio),
    .irq_temporizador (irq_temporizador),
    .err_bus          (err_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
    checks++;
    if (act !== esp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h t=%0t", nombre, act, esp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [0:RAM_WORDS-1];
  bit          m_val [0:RAM_WORDS-1];
  logic [31:0] m_cnt = '0, m_cmp = '0;
  logic [7:0]  m_gpio = '0;
  bit          m_irq = 1'b0, m_err = 1'b0;
  logic [31:0] e_rd = '0;
  bit          e_known = 1'b1;
  bit          es_ram, es_perif, err_now, match_now, clr_irq, clr_err;
  logic [31:0] base;
  int          idx;

  initial for (int i = 0; i < RAM_WORDS; i++) m_val[i] = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = '0; m_cmp = '0; m_gpio = '0; m_irq = 1'b0; m_err = 1'b0;
      e_rd = '0; e_known = 1'b1;
    end else begin
      es_ram    = dir < RAM_BYTES;
      es_perif  = (dir >= DIR_GPIO) && (dir < DIR_ESTADO + 32'd4);
      err_now   = !(es_ram || es_perif) || (hab_escritura && (dir % 4 != 0));
      base      = dir - (dir % 4);
      idx       = int'(dir / 4);
      match_now = TIMER && (m_cnt == m_cmp);
      clr_irq   = 1'b0;
      clr_err   = 1'b0;
      e_rd      = '0;
      e_known   = 1'b1;
      if (!err_now) begin
        if (es_ram) begin
          e_rd = m_mem[idx];
          e_known = m_val[idx];
        end else if (base == DIR_GPIO)       e_rd = {24'd0, m_gpio};
        else if (base == DIR_CONTADOR)       e_rd = TIMER ? m_cnt : 32'd0;
        else if (base == DIR_COMPARADOR)     e_rd = TIMER ? m_cmp : 32'd0;
        else                                 e_rd = {30'd0, m_err, m_irq};
        if (hab_escritura) begin
          if (es_ram) begin
            m_mem[idx] = dat_escritura;
            m_val[idx] = 1'b1;
          end else if (base == DIR_GPIO)       m_gpio = dat_escritura[7:0];
          else if (base == DIR_COMPARADOR) begin
            if (TIMER) m_cmp = dat_escritura;
          end else if (base == DIR_ESTADO) begin
            clr_irq = dat_escritura[0];
            clr_err = dat_escritura[1];
          end
        end
      end
      if (match_now) m_irq = 1'b1;
      else if (clr_irq) m_irq = 1'b0;
      if (err_now) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
      if (TIMER) m_cnt = m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (e_known) chk("cyc_dat_lectura", dat_lectura, e_rd);
      chk("cyc_salida_gpio", {24'd0, salida_gpio}, {24'd0, m_gpio});
      chk("cyc_irq", {31'd0, irq_temporizador}, {31'd0, m_irq});
      chk("cyc_err", {31'd0, err_bus}, {31'd0, m_err});
    end
  end

  // One bus cycle: drive, wait for the edge, settle #1 after it.
  task automatic ciclo(input logic [31:0] d, input logic [31:0] w, input logic we);
    dir = d;
    dat_escritura = w;
    hab_escritura = we;
    @(posedge clk);
    #1;
    $display("txn t=%0t dir=%08h we=%0b wdata=%08h rdata=%08h", $time, d, we, w, dat_lectura);
  endtask

  logic [31:0] rd, rw;
  int          sel, palabra;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dat_lectura", dat_lectura, 32'h0);
    chk("reset_gpio", {24'd0, salida_gpio}, 32'h0);
    chk("reset_irq", {31'd0, irq_temporizador}, 32'h0);
    chk("reset_err", {31'd0, err_bus}, 32'h0);
    chk_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;

`ifdef CONTROLADOR_MEMORIA_TEMPORIZADOR_EN
    ciclo(DIR_COMPARADOR, 32'd20, 1'b1);
    ciclo(DIR_ESTADO, 32'h1, 1'b1);
    chk("irq_cleared_w1c", {31'd0, irq_temporizador}, 32'h0);
    repeat (18) ciclo(DIR_GPIO, 32'h0, 1'b0);
    chk("irq_before_match", {31'd0, irq_temporizador}, 32'h0);
    ciclo(DIR_GPIO, 32'h0, 1'b0);
    chk("irq_after_match", {31'd0, irq_temporizador}, 32'h1);
    ciclo(DIR_CONTADOR, 32'h0, 1'b0);
    chk("contador_read", dat_lectura, 32'd21);
    ciclo(DIR_ESTADO, 32'h1, 1'b1);
    chk("irq_w1c", {31'd0, irq_temporizador}, 32'h0);
`else
    ciclo(DIR_CONTADOR, 32'h1234, 1'b1);
    ciclo(DIR_CONTADOR, 32'h0, 1'b0);
    chk("notimer_contador", dat_lectura, 32'h0);
    chk("notimer_err", {31'd0, err_bus}, 32'h0);
    chk("notimer_irq", {31'd0, irq_temporizador}, 32'h0);
`endif

    ciclo(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    ciclo(32'h0000_0010, 32'h0, 1'b0);
    chk("ram_read_latency", dat_lectura, 32'hDEAD_BEEF);

    ciclo(32'h0000_0020, 32'h5, 1'b1);
    ciclo(32'h0000_0020, 32'h1, 1'b1);
    chk("read_first_old", dat_lectura, 32'h5);
    ciclo(32'h0000_0020, 32'h0, 1'b0);
    chk("read_first_new", dat_lectura, 32'h1);

    ciclo(32'h0000_0000, 32'h1111_1111, 1'b1);
    ciclo(32'h4000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("err_unmapped_write", {31'd0, err_bus}, 32'h1);
    ciclo(DIR_ESTADO, 32'h2, 1'b1);
    ciclo(32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
    chk("err_misaligned_write", {31'd0, err_bus}, 32'h1);
    ciclo(32'h0000_0000, 32'h0, 1'b0);
    chk("ram_unchanged", dat_lectura, 32'h1111_1111);
    ciclo(32'h4000_0000, 32'h0, 1'b0);
    chk("unmapped_read_zero", dat_lectura, 32'h0);
    ciclo(DIR_ESTADO, 32'h2, 1'b1);
    chk("err_w1c", {31'd0, err_bus}, 32'h0);
    ciclo(32'h0000_0003, 32'h0, 1'b0);
    chk("misaligned_read_ok", dat_lectura, 32'h1111_1111);

    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      rw  = $urandom;
      if (sel <= 4) begin
        palabra = int'($urandom_range(0, 63));
        if (palabra == 4) palabra = 5;
        rd = 32'(palabra * 4);
        if ($urandom_range(0, 3) == 0) rd = rd + 32'($urandom_range(0, 3));
      end else if (sel <= 7) begin
        rd = DIR_GPIO + 32'(4 * $urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) rd = rd + 32'($urandom_range(1, 3));
      end else if (sel == 8) begin
        rd = ($urandom_range(0, 1) == 0) ? (RAM_BYTES + 32'($urandom_range(0, 255))) :
                                            (32'h4000_0000 + $urandom_range(0, 255));
      end else begin
        rd = 32'h0000_0020;
      end
      ciclo(rd, rw, 1'($urandom_range(0, 1)));
    end

    ciclo(DIR_GPIO, 32'h0000_00A5, 1'b1);
    chk("gpio_a5", {24'd0, salida_gpio}, 32'hA5);
    reset = 1'b0;
    #1;
    chk("async_reset_gpio", {24'd0, salida_gpio}, 32'h0);
    chk("async_reset_dat", dat_lectura, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ciclo(DIR_CONTADOR, 32'h0, 1'b0);
    chk("contador_restart", dat_lectura, 32'h0);
    ciclo(32'h0000_0010, 32'h0, 1'b0);
    chk("ram_kept_over_reset", dat_lectura, 32'hDEAD_BEEF);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controlador_memoria.md
CONTROLADOR_MEMORIA -- requirements
Module: controlador_memoria

Interface
REQ-001 SHALL have parameter ANCHO_DIR, default 10, giving the RAM word-address width (2^ANCHO_DIR 32-bit words).
REQ-002 SHALL have parameter ARCHIVO_INIT, default "" (empty), giving the hex file preloaded into RAM at elaboration; an empty value means no preload.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port dir, input, 32 bits: byte address from the CPU.
REQ-006 SHALL have port dat_escritura, input, 32 bits: store data.
REQ-007 SHALL have port hab_escritura, input, 1 bit: write strobe, active high.
REQ-008 SHALL have port dat_lectura, output, 32 bits: registered read data.
REQ-009 SHALL have port salida_gpio, output, 8 bits: general-purpose output register.
REQ-010 SHALL have port irq_temporizador, output, 1 bit: sticky timer-match flag.
REQ-011 SHALL have port err_bus, output, 1 bit: sticky bus-error flag.

Function
REQ-012 SHALL decode the following memory map:
- RAM at 0x0000_0000 .. 4*2^ANCHO_DIR-1.
- GPIO at 0x8000_0000 (RW, bits [7:0]).
- CONTADOR at 0x8000_0004 (RO).
- COMPARADOR at 0x8000_0008 (RW).
- ESTADO at 0x8000_000C: bit0 = irq flag, bit1 = err flag; W1C.
REQ-013 SHALL register every read: dat_lectura on edge N+1 reflects dir sampled at edge N (latency 1 cycle), for every address, every cycle, independent of hab_escritura.
REQ-014 SHALL perform writes at the rising edge where hab_escritura=1; writes use dir[31:2] as the word index.
REQ-015 SHALL give read-first behaviour on a RAM read and write to the same word in the same cycle: dat_lectura returns the old contents.
REQ-016 SHALL run CONTADOR as a free-running 32-bit counter, +1 every cycle, wrapping 0xFFFF_FFFF -> 0; writes to CONTADOR SHALL be ignored without error.
REQ-017 SHALL set the irq flag on the edge following any cycle where CONTADOR == COMPARADOR.
REQ-018 SHALL, when a W1C clear of ESTADO coincides with a set event for the same bit, let the set win.
REQ-019 SHALL treat any access (read or write) to an unmapped address, or with dir[1:0] != 0 while hab_escritura=1, as a bus error:
- err flag set.
- Write suppressed.
- Read returns 0x0000_0000.
REQ-020 SHALL return zero in unused bits of GPIO and ESTADO reads; SHALL drive irq_temporizador and err_bus directly from the flags.
REQ-021 SHALL ignore dir[1:0] on reads (word-aligned data returned), with no error raised for misaligned reads.

Reset
REQ-022 SHALL, while reset=0, asynchronously clear dat_lectura, salida_gpio, CONTADOR, COMPARADOR, the irq flag and the err flag to 0.
REQ-023 SHALL leave RAM contents unchanged on reset.
REQ-024 SHALL suppress any write coincident with active reset.
REQ-025 SHALL restart counting from 0 on the first edge after reset release.

Configuration
REQ-026 SHALL, with CONTROLADOR_MEMORIA_TEMPORIZADOR_EN defined, implement CONTADOR, COMPARADOR and the irq flag as above.
REQ-027 SHALL, without CONTROLADOR_MEMORIA_TEMPORIZADOR_EN, apply the following:
- CONTADOR and COMPARADOR read 0.
- Writes to them are ignored.
- Accesses to them are not errors.
- ESTADO bit0 reads 0.
- irq_temporizador is tied to 0.
- No counter flops are synthesized.

Structure
REQ-028 SHALL place the memory-map base/offset constants and region-select encoding in a shared package, reused by the testbench and future peripherals.
REQ-029 SHALL use exactly one sub-module, ram_sincrona: a single-port, read-first, synchronous RAM parameterised by ANCHO_DIR and ARCHIVO_INIT; decode, registers and the read mux stay in controlador_memoria.

Verification
REQ-030 SHALL cover: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> dat_lectura=0xDEADBEEF exactly 1 cycle after dir is presented.
REQ-031 SHALL cover: same-cycle write 0x1 and read of 0x0000_0020 holding 0x5 -> dat_lectura=0x5; next read -> 0x1.
REQ-032 SHALL cover: write COMPARADOR=20 after reset -> irq_temporizador rises at the edge after CONTADOR==20; W1C 0x1 to ESTADO -> irq clears.
REQ-033 SHALL cover: write to 0x4000_0000 or to 0x0000_0002 -> err_bus=1, RAM unchanged, read of 0x4000_0000 returns 0; W1C 0x2 -> err_bus=0.
REQ-034 SHALL cover: reset asserted mid-count with GPIO=0xA5 -> salida_gpio=0 and CONTADOR=0 immediately, and RAM at 0x0000_0010 still 0xDEADBEEF afterwards.
REQ-035 SHALL cover: build without CONTROLADOR_MEMORIA_TEMPORIZADOR_EN -> read of 0x8000_0004 returns 0 with err_bus=0, and irq_temporizador stays 0.
